// File: rtl/vga_scanout_reader.sv
// Scan-out side of the 160x120 framebuffer: 640x480@60 VGA timing from CLOCK_50,
// 4x4 pixel replication, one-pixel read/output pipeline and a frame-start pulse.
module vga_scanout_reader #(
  parameter int unsigned HVisible = 640,
  parameter int unsigned HFront   = 16,
  parameter int unsigned HSync    = 96,
  parameter int unsigned HBack    = 48,
  parameter int unsigned VVisible = 480,
  parameter int unsigned VFront   = 10,
  parameter int unsigned VSync    = 2,
  parameter int unsigned VBack    = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  localparam int unsigned HTotal = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal = VVisible + VFront + VSync + VBack;

  localparam logic [9:0]  HLast      = 10'(HTotal - 1);
  localparam logic [9:0]  VLast      = 10'(VTotal - 1);
  localparam logic [9:0]  HVisW      = 10'(HVisible);
  localparam logic [9:0]  VVisW      = 10'(VVisible);
  localparam logic [9:0]  HSyncFirst = 10'(HVisible + HFront);
  localparam logic [9:0]  HSyncLast  = 10'(HVisible + HFront + HSync - 1);
  localparam logic [9:0]  VSyncFirst = 10'(VVisible + VFront);
  localparam logic [9:0]  VSyncLast  = 10'(VVisible + VFront + VSync - 1);
  // One stored pixel covers four screen columns, so a stored row is HVisible/4 wide.
  localparam logic [14:0] Stride     = 15'(HVisible / 4);

  logic       pix_en_q, pix_en_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic [2:0] colour_q, colour_d;
  logic       vga_clk_q, vga_clk_d;
  logic       frame_start_q, frame_start_d;
  logic       visible;

  always_comb begin
    visible = (hcount_q < HVisW) && (vcount_q < VVisW);
    rd_addr = 15'd0;
    if (visible) begin
      rd_addr = 15'(vcount_q[9:2]) * Stride + 15'(hcount_q[9:2]);
    end
  end

  always_comb begin
    pix_en_d      = ~pix_en_q;
    vga_clk_d     = ~pix_en_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    colour_d      = colour_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      // Outputs are all taken from the current counter value, before it advances.
      hs_d      = !((hcount_q >= HSyncFirst) && (hcount_q <= HSyncLast));
      vs_d      = !((vcount_q >= VSyncFirst) && (vcount_q <= VSyncLast));
      blank_n_d = visible;
      colour_d  = visible ? rd_data : 3'b000;
      if (hcount_q == HLast) begin
        hcount_d = 10'd0;
        if (vcount_q == VLast) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pix_en_q      <= 1'b0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      colour_q      <= 3'b000;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      colour_q      <= colour_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {10{colour_q[2]}};
  assign VGA_G       = {10{colour_q[1]}};
  assign VGA_B       = {10{colour_q[0]}};

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench: full-size scanner for address map/colour/HS, reduced-geometry copy for VS and
// frame pulses; both checked every cycle against a pixel-index model.
module tb_vga_scanout_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edges;
  logic        run_chk = 1'b0;

  logic [2:0] mem_b [0:19199];
  logic [2:0] mem_s [0:127];

  logic [14:0] rd_addr_b, rd_addr_s;
  logic [2:0]  rd_data_b, rd_data_s;
  logic        fs_b, vclk_b, hs_b, vs_b, blank_b, syncn_b;
  logic        fs_s, vclk_s, hs_s, vs_s, blank_s, syncn_s;
  logic [9:0]  r_b, g_b, b_b, r_s, g_s, b_s;

  vga_scanout_reader u_big (
    .CLOCK_50(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .frame_start(fs_b), .VGA_CLK(vclk_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(blank_b), .VGA_SYNC_N(syncn_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  vga_scanout_reader #(
    .HVisible(32), .HFront(4), .HSync(8), .HBack(4),
    .VVisible(16), .VFront(2), .VSync(2), .VBack(3)
  ) u_small (
    .CLOCK_50(clk), .reset(reset), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .frame_start(fs_s), .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
    .VGA_BLANK_N(blank_s), .VGA_SYNC_N(syncn_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
  );

  // Synchronous-read pixel memories: data one cycle after address.
  always @(posedge clk) begin
    rd_data_b <= mem_b[rd_addr_b];
    rd_data_s <= mem_s[rd_addr_s[6:0]];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: after e clock edges from reset release, counters hold pixel e/2 and the
  // pins show pixel e/2-1; each frame wrap lands on an edge that is a multiple of 2*H*V.
  task automatic check_inst(
    input string name, input logic big, input int unsigned e,
    input int unsigned hv, input int unsigned hf, input int unsigned hsw, input int unsigned hb,
    input int unsigned vv, input int unsigned vf, input int unsigned vsw, input int unsigned vb,
    input logic [14:0] addr, input logic fs, input logic vclk, input logic hs, input logic vs,
    input logic blank, input logic syncn, input logic [9:0] r, input logic [9:0] g,
    input logic [9:0] b
  );
    int unsigned ht, vt, p, h, v, exp_addr, q, qh, qv, qa;
    logic vis;
    logic [2:0] c;
    logic exp_hs, exp_vs;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p = e / 2;
    h = p % ht;
    v = (p / ht) % vt;
    exp_addr = (h < hv && v < vv) ? (v / 4) * (hv / 4) + h / 4 : 0;
    check_eq({name, ".rd_addr"}, 32'(addr), exp_addr);
    check_eq({name, ".vga_clk"}, 32'(vclk), e % 2);
    check_eq({name, ".frame_start"}, 32'(fs), (e > 0 && e % (2 * ht * vt) == 0) ? 1 : 0);
    check_eq({name, ".sync_n"}, 32'(syncn), 1);
    if (e >= 2) begin
      q = p - 1;
      qh = q % ht;
      qv = (q / ht) % vt;
      vis = (qh < hv) && (qv < vv);
      qa = (qv / 4) * (hv / 4) + qh / 4;
      c = vis ? (big ? mem_b[qa] : mem_s[qa]) : 3'b000;
      exp_hs = !(qh >= hv + hf && qh < hv + hf + hsw);
      exp_vs = !(qv >= vv + vf && qv < vv + vf + vsw);
    end else begin
      vis = 1'b0;
      c = 3'b000;
      exp_hs = 1'b1;
      exp_vs = 1'b1;
    end
    check_eq({name, ".hs"}, 32'(hs), 32'(exp_hs));
    check_eq({name, ".vs"}, 32'(vs), 32'(exp_vs));
    check_eq({name, ".blank_n"}, 32'(blank), 32'(vis));
    check_eq({name, ".r"}, 32'(r), c[2] ? 32'h3ff : 32'h0);
    check_eq({name, ".g"}, 32'(g), c[1] ? 32'h3ff : 32'h0);
    check_eq({name, ".b"}, 32'(b), c[0] ? 32'h3ff : 32'h0);
  endtask

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      check_inst("big", 1'b1, edges, 640, 16, 96, 48, 480, 10, 2, 33,
                 rd_addr_b, fs_b, vclk_b, hs_b, vs_b, blank_b, syncn_b, r_b, g_b, b_b);
      check_inst("small", 1'b0, edges, 32, 4, 8, 4, 16, 2, 2, 3,
                 rd_addr_s, fs_s, vclk_s, hs_s, vs_s, blank_s, syncn_s, r_s, g_s, b_s);
    end
  end

  task automatic check_reset_pins();
    check_eq("rst.rd_addr", 32'(rd_addr_b), 0);
    check_eq("rst.hs", 32'(hs_b), 1);
    check_eq("rst.vs", 32'(vs_b), 1);
    check_eq("rst.blank_n", 32'(blank_b), 0);
    check_eq("rst.rgb", {2'b0, r_b, g_b, b_b}, 0);
    check_eq("rst.vga_clk", 32'(vclk_b), 0);
    check_eq("rst.frame_start", 32'(fs_b), 0);
    check_eq("rst.small_rd_addr", 32'(rd_addr_s), 0);
    check_eq("rst.small_pins", {hs_s, vs_s, blank_s, vclk_s, fs_s}, 5'b11000);
  endtask

  initial begin
    // Constant 3'b101 memory first: visible pixels must be magenta, blank black.
    for (int i = 0; i < 19200; i++) mem_b[i] = 3'b101;
    for (int i = 0; i < 128; i++) mem_s[i] = 3'b101;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    run_chk = 1'b1;
    repeat (5000) @(negedge clk);

    // Asynchronous reset partway through a line and a small-geometry frame.
    run_chk = 1'b0;
    #3 reset = 1'b1;
    #1 check_reset_pins();
    for (int i = 0; i < 19200; i++) mem_b[i] = 3'($urandom);
    for (int i = 0; i < 128; i++) mem_s[i] = 3'($urandom);
    repeat (2) @(negedge clk);
    check_reset_pins();
    #2 reset = 1'b0;
    run_chk = 1'b1;
    repeat (52000) @(negedge clk);
    run_chk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
